// File: rtl/batch_mul_if.sv
// Memory-side bundle of the batch multiply engine.
//   rd_req_*  : line read requests (valid/ready) with line address
//   rd_rsp_*  : in-order read data, no backpressure
//   wr_req_*  : line write requests (valid/ready) with address and data
// master = engine side, slave = memory side.
interface batch_mul_if #(
    parameter int ADDR_W    = 42,
    parameter int LINE_BITS = 512
);
    logic                 rd_req_valid;
    logic                 rd_req_ready;
    logic [ADDR_W-1:0]    rd_req_addr;
    logic                 rd_rsp_valid;
    logic [LINE_BITS-1:0] rd_rsp_data;
    logic                 wr_req_valid;
    logic                 wr_req_ready;
    logic [ADDR_W-1:0]    wr_req_addr;
    logic [LINE_BITS-1:0] wr_req_data;

    modport master (
        output rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data,
        input  rd_req_ready, rd_rsp_valid, rd_rsp_data, wr_req_ready
    );

    modport slave (
        input  rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data,
        output rd_req_ready, rd_rsp_valid, rd_rsp_data, wr_req_ready
    );
endinterface

// File: rtl/batch_mul_engine.sv
// Streams num_lines cache lines of packed operand pairs through LANES pipelined
// multipliers and writes the full-width products back as cache lines.
// Ports:
//   clk, reset (async, active-high)
//   start / clear       : job launch (IDLE only) / synchronous abort
//   signed_mode, src_addr, dst_addr, num_lines : job config, sampled at start
//   bus (master)        : read request/response and write request channels
//   busy, done          : RUN/DRAIN indicator, 1-cycle completion pulse
//   cycle_count         : cycles from start acceptance to done (saturating)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing reads (credit-limited), products flowing to FIFO/writes
// DRAIN | all reads issued, waiting for the remaining writes to be accepted
// DONE  | one-cycle completion pulse
module batch_mul_engine #(
    parameter int DATA_LEN       = 32,
    parameter int PIPELINE_STAGE = 2,
    parameter int LINE_BITS      = 512,
    parameter int FIFO_DEPTH     = 8,
    parameter int ADDR_W         = 42,
    parameter int CNT_W          = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                clear,
    input  logic                signed_mode,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [CNT_W-1:0]    num_lines,
    batch_mul_if.master         bus,
    output logic                busy,
    output logic                done,
    output logic [31:0]         cycle_count
);
    localparam int LANES = LINE_BITS / (2 * DATA_LEN);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 2;  // holds outstanding + pipeline + fifo (<= 3*FIFO_DEPTH)

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0]    src_q, dst_q;
    logic [CNT_W-1:0]     num_q, reads_issued, writes_done;
    logic                 signed_q;
    logic [CW-1:0]        outstanding, pipe_cnt, credits_used;
    logic [PIPELINE_STAGE-1:0] pipe_vld;
    logic [LINE_BITS-1:0] pipe_data [PIPELINE_STAGE];
    logic [LINE_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]        wptr, rptr;
    logic [PW:0]          fifo_cnt;
    logic [LINE_BITS-1:0] products;
    logic [DATA_LEN-1:0]  op_a, op_b;
    logic [2*DATA_LEN-1:0] ext_a, ext_b;
    logic                 active, start_ok, rd_fire, rsp_take, push, pop;

    assign active   = (state == RUN) || (state == DRAIN);
    assign start_ok = (state == IDLE) && start && !clear;

    always_comb begin
        pipe_cnt = '0;
        for (int i = 0; i < PIPELINE_STAGE; i++) pipe_cnt = pipe_cnt + CW'(pipe_vld[i]);
    end

    // Every line in flight already owns a FIFO slot, so responses can never overflow it.
    assign credits_used     = outstanding + pipe_cnt + CW'(fifo_cnt);
    assign bus.rd_req_valid = (state == RUN) && (reads_issued < num_q) &&
                              (credits_used < CW'(FIFO_DEPTH));
    assign bus.rd_req_addr  = src_q + ADDR_W'(reads_issued);
    assign rd_fire          = bus.rd_req_valid && bus.rd_req_ready;
    assign rsp_take         = bus.rd_rsp_valid && active;

    assign push             = pipe_vld[PIPELINE_STAGE-1];
    assign bus.wr_req_valid = (fifo_cnt != '0);
    assign bus.wr_req_addr  = dst_q + ADDR_W'(writes_done);
    assign bus.wr_req_data  = bus.wr_req_valid ? fifo_mem[rptr] : '0;
    assign pop              = bus.wr_req_valid && bus.wr_req_ready;

    // Operands are extended to full product width first, so the low 2*DATA_LEN bits
    // of the product are exact for both signed and unsigned operation.
    always_comb begin
        products = '0;
        op_a     = '0;
        op_b     = '0;
        ext_a    = '0;
        ext_b    = '0;
        for (int i = 0; i < LANES; i++) begin
            op_a  = bus.rd_rsp_data[2*i*DATA_LEN +: DATA_LEN];
            op_b  = bus.rd_rsp_data[2*i*DATA_LEN+DATA_LEN +: DATA_LEN];
            ext_a = signed_q ? {{DATA_LEN{op_a[DATA_LEN-1]}}, op_a} : {{DATA_LEN{1'b0}}, op_a};
            ext_b = signed_q ? {{DATA_LEN{op_b[DATA_LEN-1]}}, op_b} : {{DATA_LEN{1'b0}}, op_b};
            products[2*i*DATA_LEN +: 2*DATA_LEN] = ext_a * ext_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_vld <= '0;
        end else if (clear) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= rsp_take;
            for (int i = 1; i < PIPELINE_STAGE; i++) pipe_vld[i] <= pipe_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pipe_data[0] <= products;
        for (int i = 1; i < PIPELINE_STAGE; i++) pipe_data[i] <= pipe_data[i-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            fifo_cnt <= '0;
        end else if (clear) begin
            wptr     <= '0;
            rptr     <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) fifo_mem[wptr] <= pipe_data[PIPELINE_STAGE-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            num_q        <= '0;
            signed_q     <= 1'b0;
            reads_issued <= '0;
            writes_done  <= '0;
            outstanding  <= '0;
            cycle_count  <= '0;
        end else begin
            state <= state_nxt;
            if (clear) begin
                outstanding <= '0;
            end else if (start_ok) begin
                src_q        <= src_addr;
                dst_q        <= dst_addr;
                num_q        <= num_lines;
                signed_q     <= signed_mode;
                reads_issued <= '0;
                writes_done  <= '0;
                outstanding  <= '0;
                cycle_count  <= 32'd1;
            end else begin
                if (rd_fire) reads_issued <= reads_issued + 1'b1;
                if (pop && active) writes_done <= writes_done + 1'b1;
                case ({rd_fire, rsp_take && (outstanding != '0)})
                    2'b10:   outstanding <= outstanding + 1'b1;
                    2'b01:   outstanding <= outstanding - 1'b1;
                    default: outstanding <= outstanding;
                endcase
                if (active && (cycle_count != '1)) cycle_count <= cycle_count + 32'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:    if (start_ok) state_nxt = (num_lines == '0) ? DONE : RUN;
            RUN: begin
                busy = 1'b1;
                if (reads_issued == num_q) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (writes_done == num_q) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end
endmodule
